// File: rtl/store_buffer_pkg.sv
// Shared types for the posted-write store buffer: drain FSM encoding and the buffered entry record.
package store_buffer_pkg;

  localparam int SB_AW = 32;
  localparam int SB_DW = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RDONE = 2'd3
  } sb_state_t;

  typedef struct packed {
    logic [SB_AW-1:0] addr;
    logic [SB_DW-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/sb_fifo.sv
// Circular FIFO of buffered stores; exposes head, next head and a flat entry/valid view for load matching.
module sb_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic [W-1:0]                  push_data,
  input  logic                          pop,
  output logic [W-1:0]                  head,
  output logic [W-1:0]                  head_next,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(DEPTH):0]        count,
  output logic [DEPTH-1:0][W-1:0]       entries,
  output logic [DEPTH-1:0]              valid,
  output logic [$clog2(DEPTH)-1:0]      rd_idx
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [PW-1:0]           wr_ptr;
  logic [PW-1:0]           rd_ptr;
  logic [PW-1:0]           rd_ptr_next;
  logic [PW:0]             cnt;
  logic [PW-1:0]           age_v;
  logic                    do_push;
  logic                    do_pop;

  assign full        = (cnt == (PW+1)'(DEPTH));
  assign empty       = (cnt == '0);
  assign do_push     = push && !full;
  assign do_pop      = pop && !empty;
  assign rd_ptr_next = rd_ptr + PTR_ONE;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr_next;
      cnt <= cnt + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
    end
  end

  // Storage carries no reset; occupancy is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (!reset && do_push) mem[wr_ptr] <= push_data;
  end

  always_comb begin
    valid = '0;
    age_v = '0;
    for (int i = 0; i < DEPTH; i++) begin
      age_v    = PW'(i) - rd_ptr;
      valid[i] = ({1'b0, age_v} < cnt);
    end
  end

  assign head      = mem[rd_ptr];
  assign head_next = mem[rd_ptr_next];
  assign count     = cnt;
  assign entries   = mem;
  assign rd_idx    = rd_ptr;

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer between the CPU data port and a handshaked RAM.
// STORE_BUF_FWD_EN enables load forwarding from buffered stores; otherwise loads drain the buffer first.
//
// state | meaning
// IDLE  | no memory request outstanding
// WRITE | head entry being written to memory, popped on mem_ack
// READ  | load miss reading memory at cpu_addr
// RDONE | load data in rd_hold, load retires this cycle
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = SB_AW,
  parameter int DW    = SB_DW
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cpu_we,
  input  logic                   cpu_re,
  input  logic [AW-1:0]          cpu_addr,
  input  logic [DW-1:0]          cpu_wdata,
  output logic [DW-1:0]          cpu_rdata,
  output logic                   stall,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [AW-1:0]          mem_addr,
  output logic [DW-1:0]          mem_wdata,
  input  logic                   mem_ack,
  input  logic [DW-1:0]          mem_rdata,
  output logic [$clog2(DEPTH):0] buf_count,
  output logic                   buf_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int EW = $bits(sb_entry_t);
  localparam logic [PW:0] CNT_ONE = (PW+1)'(1);

  sb_state_t                state;
  sb_entry_t                push_entry;
  sb_entry_t                head_entry;
  sb_entry_t                head_next_entry;
  logic [DEPTH-1:0][EW-1:0] fifo_entries;
  logic [DEPTH-1:0]         fifo_valid;
  logic [PW-1:0]            fifo_rd_idx;
  logic                     full;
  logic                     empty;
  logic [PW:0]              count;
  logic                     push;
  logic                     pop;
  logic [DW-1:0]            rd_hold;
  logic                     fwd_hit;
  logic [DW-1:0]            fwd_data;
  logic                     load_wait;
  logic                     read_ok;
  logic                     read_ok_after_pop;
  logic                     unused_bits;

  assign push_entry = '{addr: cpu_addr, data: cpu_wdata};
  assign push       = cpu_we && !full;
  assign pop        = (state == WRITE) && mem_ack;

  sb_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head_entry),
    .head_next (head_next_entry),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .entries   (fifo_entries),
    .valid     (fifo_valid),
    .rd_idx    (fifo_rd_idx)
  );

  assign load_wait = cpu_re && !cpu_we && !fwd_hit;

`ifdef STORE_BUF_FWD_EN
  sb_entry_t     fwd_e;
  logic [PW-1:0] fwd_idx;

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_e    = '0;
    fwd_idx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      fwd_idx = fifo_rd_idx + PW'(k);
      fwd_e   = fifo_entries[fwd_idx];
      if (fifo_valid[fwd_idx] && (fwd_e.addr[AW-1:2] == cpu_addr[AW-1:2])) begin
        fwd_hit  = 1'b1;
        fwd_data = fwd_e.data;
      end
    end
  end

  assign read_ok           = load_wait;
  assign read_ok_after_pop = load_wait;
  assign unused_bits       = ^fifo_entries;
`else
  assign fwd_hit           = 1'b0;
  assign fwd_data          = '0;
  assign read_ok           = load_wait && empty;
  assign read_ok_after_pop = load_wait && (count == CNT_ONE);
  assign unused_bits       = ^{fifo_entries, fifo_valid, fifo_rd_idx};
`endif

  always_comb begin
    stall = 1'b0;
    if (!reset) begin
      if (cpu_we)      stall = full;
      else if (cpu_re) stall = !fwd_hit && (state != RDONE);
    end
  end

  assign cpu_rdata = (cpu_re && fwd_hit) ? fwd_data : rd_hold;
  assign buf_count = count;
  assign buf_empty = empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rd_hold   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (read_ok) begin
            state    <= READ;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= cpu_addr;
          end else if (!empty) begin
            state     <= WRITE;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= head_entry.addr;
            mem_wdata <= head_entry.data;
          end
        end
        WRITE: begin
          if (mem_ack) begin
            if (read_ok_after_pop) begin
              state    <= READ;
              mem_we   <= 1'b0;
              mem_addr <= cpu_addr;
            end else if (count > CNT_ONE) begin
              mem_addr  <= head_next_entry.addr;
              mem_wdata <= head_next_entry.data;
            end else begin
              state   <= IDLE;
              mem_req <= 1'b0;
              mem_we  <= 1'b0;
            end
          end
        end
        READ: begin
          if (mem_ack) begin
            rd_hold <= mem_rdata;
            mem_req <= 1'b0;
            state   <= RDONE;
          end
        end
        RDONE:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: reset state, directed corner sequences, a vector table
// and a randomized program checked against a program-order memory model.
module tb_store_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_we, cpu_re;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        stall;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  buf_count;
  logic        buf_empty;

  store_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
    .clk(clk), .reset(reset), .cpu_we(cpu_we), .cpu_re(cpu_re), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .stall(stall), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .buf_count(buf_count), .buf_empty(buf_empty)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic we; logic [31:0] addr; logic [31:0] data; } txn_t;
  typedef struct packed { logic [31:0] addr; logic [31:0] data; } wr_t;
  typedef struct { bit is_load; logic [31:0] addr; logic [31:0] data; } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   lat = 2;
  bit   ack_en = 1'b1;
  bit   force_ack = 1'b0;
  bit   chk_wr = 1'b0;
  txn_t log_q[$];
  wr_t  exp_w[$];
  logic [31:0] ram     [logic [29:0]];
  logic [31:0] ref_mem [logic [29:0]];

  function automatic logic [31:0] dflt(logic [31:0] a);
    return ~{a[31:2], 2'b00};
  endfunction

  function automatic logic [31:0] rd_word(logic [31:0] a);
    if (ram.exists(a[31:2])) return ram[a[31:2]];
    return dflt(a);
  endfunction

  function automatic txn_t get_log(int i);
    txn_t t;
    t = '0;
    if (i < log_q.size()) t = log_q[i];
    return t;
  endfunction

  task automatic check(string name, logic [95:0] act, logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory responder: acks a request in its lat-th cycle; force_ack drives a pulse regardless.
  initial begin
    int  age;
    wr_t e;
    age = 0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      if (mem_ack) age = 0;
      if (mem_req) age++; else age = 0;
      mem_ack = 1'b0;
      if (force_ack) mem_ack = 1'b1;
      if (mem_req && ((ack_en && age >= lat) || force_ack)) begin
        mem_ack = 1'b1;
        if (mem_we) begin
          ram[mem_addr[31:2]] = mem_wdata;
          log_q.push_back('{we: 1'b1, addr: mem_addr, data: mem_wdata});
          if (chk_wr) begin
            if (exp_w.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL wr_extra: got write %h expected none", mem_addr);
            end else begin
              e = exp_w.pop_front();
              check("wr_order", {32'b0, mem_addr, mem_wdata}, {32'b0, e.addr, e.data});
            end
          end
        end else begin
          mem_rdata = rd_word(mem_addr);
          log_q.push_back('{we: 1'b0, addr: mem_addr, data: mem_rdata});
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; cpu_we = 1'b0; cpu_re = 1'b0; force_ack = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, output int st);
    bit done;
    st = 0; done = 1'b0;
    cpu_we = 1'b1; cpu_re = 1'b0; cpu_addr = a; cpu_wdata = d;
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge clk);
      if (!stall) done = 1'b1; else st++;
      tick();
    end
    cpu_we = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL store_timeout: store %h still stalled, expected retire", a);
    end
  endtask

  task automatic do_load(input logic [31:0] a, output logic [31:0] d, output int st);
    bit done;
    st = 0; done = 1'b0; d = 'x;
    cpu_re = 1'b1; cpu_we = 1'b0; cpu_addr = a;
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge clk);
      if (!stall) begin done = 1'b1; d = cpu_rdata; end
      else st++;
      tick();
    end
    cpu_re = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL load_timeout: load %h still stalled, expected retire", a);
    end
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge clk);
      done = buf_empty && !mem_req;
      tick();
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL drain_timeout: buffer not drained, count %0d expected 0", buf_count);
    end
  endtask

  initial begin
    vec_t        tbl[10];
    txn_t        t;
    txn_t        exp5[4];
    logic [31:0] d;
    int          st;
    int          nlog;

    reset = 1'b1; cpu_we = 1'b0; cpu_re = 1'b1; cpu_addr = 32'h40; cpu_wdata = '0;
    tick();
    @(negedge clk);
    check("stall_in_reset", 96'(stall), 96'(0));
    tick();
    reset = 1'b0; cpu_re = 1'b0;
    @(negedge clk);
    check("rst_mem_req", 96'(mem_req), 96'(0));
    check("rst_mem_we", 96'(mem_we), 96'(0));
    check("rst_mem_addr", 96'(mem_addr), 96'(0));
    check("rst_mem_wdata", 96'(mem_wdata), 96'(0));
    check("rst_count", 96'(buf_count), 96'(0));
    check("rst_empty", 96'(buf_empty), 96'(1));
    check("rst_stall", 96'(stall), 96'(0));
    check("rst_rdata", 96'(cpu_rdata), 96'(0));
    tick();

    // Three stores with ack latency 2 never stall and drain in order.
    lat = 2; ack_en = 1'b1; log_q.delete();
    do_store(32'h10, 32'hA, st); check("t1_stall0", 96'(st), 96'(0));
    do_store(32'h14, 32'hB, st); check("t1_stall1", 96'(st), 96'(0));
    do_store(32'h18, 32'hC, st); check("t1_stall2", 96'(st), 96'(0));
    wait_drain();
    check("t1_nlog", 96'(log_q.size()), 96'(3));
    for (int i = 0; i < 3; i++) begin
      t = get_log(i);
      check("t1_wr", {31'b0, t}, {31'b0, 1'b1, 32'h10 + 32'(4 * i), 32'hA + 32'(i)});
    end
    @(negedge clk);
    check("t1_empty", 96'(buf_empty), 96'(1));
    tick();

    // Full buffer stalls a fifth store until one ack frees a slot.
    do_reset();
    ack_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      do_store(32'h3C0 + 32'(4 * i), 32'(i), st);
      check("t2_fill", 96'(st), 96'(0));
    end
    cpu_we = 1'b1; cpu_addr = 32'h3D0; cpu_wdata = 32'h99;
    @(negedge clk);
    check("t2_full_stall", 96'(stall), 96'(1));
    check("t2_full_count", 96'(buf_count), 96'(4));
    tick();
    force_ack = 1'b1;
    @(negedge clk);
    check("t2_ack_cycle_stall", 96'(stall), 96'(1));
    tick();
    force_ack = 1'b0;
    @(negedge clk);
    check("t2_freed_stall", 96'(stall), 96'(0));
    check("t2_freed_count", 96'(buf_count), 96'(3));
    tick();
    cpu_we = 1'b0;
    @(negedge clk);
    check("t2_enq_count", 96'(buf_count), 96'(4));
    tick();

    // Two stores to one word, then a load of that word.
    do_reset();
    ack_en = 1'b0; lat = 2; log_q.delete();
    do_store(32'h20, 32'h11, st);
    do_store(32'h20, 32'h22, st);
`ifdef STORE_BUF_FWD_EN
    do_load(32'h20, d, st);
    check("t3_fwd_data", 96'(d), 96'(32'h22));
    check("t3_fwd_stall", 96'(st), 96'(0));
`else
    ack_en = 1'b1;
    do_load(32'h20, d, st);
    check("t3_data", 96'(d), 96'(32'h22));
    check("t3_stalled", 96'(st > 0), 96'(1));
    check("t3_nlog", 96'(log_q.size()), 96'(3));
    t = get_log(2);
    check("t3_read_last", {63'b0, t.we, t.addr}, {63'b0, 1'b0, 32'h20});
`endif
    ack_en = 1'b1;

    // Empty buffer load with memory latency 3.
    do_reset();
    lat = 3; ack_en = 1'b1;
    ram[30'h10] = 32'h55;
    do_load(32'h40, d, st);
    check("t4_data", 96'(d), 96'(32'h55));
    check("t4_stall_cycles", 96'(st), 96'(4));
    @(negedge clk);
    check("t4_rdata_hold", 96'(cpu_rdata), 96'(32'h55));
    tick();

    // Load miss while a write is in flight.
    do_reset();
    lat = 4; log_q.delete();
    do_store(32'h200, 32'h1, st);
    do_store(32'h204, 32'h2, st);
    do_store(32'h208, 32'h3, st);
    do_load(32'h300, d, st);
    check("t5_data", 96'(d), 96'(dflt(32'h300)));
    wait_drain();
`ifdef STORE_BUF_FWD_EN
    exp5[0] = '{1'b1, 32'h200, 32'h0}; exp5[1] = '{1'b0, 32'h300, 32'h0};
    exp5[2] = '{1'b1, 32'h204, 32'h0}; exp5[3] = '{1'b1, 32'h208, 32'h0};
`else
    exp5[0] = '{1'b1, 32'h200, 32'h0}; exp5[1] = '{1'b1, 32'h204, 32'h0};
    exp5[2] = '{1'b1, 32'h208, 32'h0}; exp5[3] = '{1'b0, 32'h300, 32'h0};
`endif
    check("t5_nlog", 96'(log_q.size()), 96'(4));
    for (int i = 0; i < 4; i++) begin
      t = get_log(i);
      check("t5_order", {63'b0, t.we, t.addr}, {63'b0, exp5[i].we, exp5[i].addr});
    end

    // Reset during WRITE with two entries; a late ack must do nothing.
    do_reset();
    lat = 2; ack_en = 1'b0;
    do_store(32'h500, 32'h5, st);
    do_store(32'h504, 32'h6, st);
    @(negedge clk);
    check("t6_pre_req", 96'(mem_req), 96'(1));
    check("t6_pre_count", 96'(buf_count), 96'(2));
    tick();
    nlog = log_q.size();
    reset = 1'b1;
    tick();
    reset = 1'b0; force_ack = 1'b1;
    @(negedge clk);
    check("t6_req_drop", 96'(mem_req), 96'(0));
    check("t6_count_clr", 96'(buf_count), 96'(0));
    tick();
    force_ack = 1'b0;
    @(negedge clk);
    check("t6_late_req", 96'(mem_req), 96'(0));
    check("t6_late_count", 96'(buf_count), 96'(0));
    check("t6_late_rdata", 96'(cpu_rdata), 96'(0));
    check("t6_late_nlog", 96'(log_q.size()), 96'(nlog));
    tick();

    // Vector table: data is the store value or the load's expected value.
    tbl[0] = '{1'b0, 32'h100, 32'h1111};
    tbl[1] = '{1'b0, 32'h104, 32'h2222};
    tbl[2] = '{1'b1, 32'h100, 32'h1111};
    tbl[3] = '{1'b1, 32'h108, 32'hFFFF_FEF7};
    tbl[4] = '{1'b0, 32'h100, 32'h3333};
    tbl[5] = '{1'b1, 32'h102, 32'h3333};
    tbl[6] = '{1'b0, 32'h10C, 32'h4444};
    tbl[7] = '{1'b0, 32'h10C, 32'h5555};
    tbl[8] = '{1'b1, 32'h10C, 32'h5555};
    tbl[9] = '{1'b1, 32'h104, 32'h2222};
    do_reset();
    ram.delete();
    ack_en = 1'b1; lat = 2;
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].is_load) begin
        do_load(tbl[i].addr, d, st);
        check($sformatf("tbl_load%0d", i), 96'(d), 96'(tbl[i].data));
      end else begin
        do_store(tbl[i].addr, tbl[i].data, st);
      end
    end
    wait_drain();
    check("tbl_ram100", 96'(rd_word(32'h100)), 96'(32'h3333));
    check("tbl_ram104", 96'(rd_word(32'h104)), 96'(32'h2222));
    check("tbl_ram10c", 96'(rd_word(32'h10C)), 96'(32'h5555));

    // Random program against a program-order memory model.
    do_reset();
    ram.delete(); ref_mem.delete(); exp_w.delete();
    chk_wr = 1'b1;
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a, wd, ed;
      lat = int'($urandom_range(1, 3));
      a = 32'h80 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 2) != 2) begin
        wd = $urandom;
        ref_mem[a[31:2]] = wd;
        exp_w.push_back('{addr: a, data: wd});
        do_store(a, wd, st);
      end else begin
        ed = ref_mem.exists(a[31:2]) ? ref_mem[a[31:2]] : dflt(a);
        do_load(a, d, st);
        check("rand_load", 96'(d), 96'(ed));
      end
      if ($urandom_range(0, 3) == 0) begin
        for (int k = 0; k < int'($urandom_range(1, 4)); k++) tick();
      end
    end
    wait_drain();
    chk_wr = 1'b0;
    check("rand_all_written", 96'(exp_w.size()), 96'(0));
    for (int w = 0; w < 8; w++) begin
      logic [31:0] a;
      a = 32'h80 + 32'(4 * w);
      check("rand_ram", 96'(rd_word(a)), 96'(ref_mem.exists(a[31:2]) ? ref_mem[a[31:2]] : dflt(a)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
